coin_input_conditioner: RTL and testbench



---
 rtl/coin_pkg.sv | 14 +
 rtl/coin_debounce.sv | 100 ++++++++++
 rtl/coin_input_conditioner.sv | 61 ++++++
 tb/tb_coin_input_conditioner.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// Shared types and constants for the coin input conditioner.
package coin_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    PRESSED   = 2'd2,
    RELEASING = 2'd3
  } deb_state_t;

  localparam int DEBOUNCE_DEFAULT = 500000;
  localparam int STUCK_MULT       = 4;

endpackage

// File: rtl/coin_debounce.sv
// One coin channel: synchronizer, debounce FSM and a single shared counter.
// Emits one accept pulse per debounced press and a sticky stuck flag.
module coin_debounce
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic accept,
  output logic active,
  output logic stuck
);

  // The counter is reused in PRESSED for the stuck span, so it must hold STUCK_MULT*DEBOUNCE_CYCLES.
  localparam int CNT_W = $clog2(STUCK_MULT * DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STUCK_LAST = CNT_W'(STUCK_MULT * DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STUCK_MAX  = CNT_W'(STUCK_MULT * DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [CNT_W-1:0]       cnt_r;
  deb_state_t             state_r;
  logic                   accept_r;
  logic                   stuck_r;
  logic                   s_s;

  assign s_s = sync_r[SYNC_STAGES-1];

  // Synchronizer shift, debounce state machine and counter
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r   <= {SYNC_STAGES{1'b0}};
      cnt_r    <= CNT_ZERO;
      state_r  <= IDLE;
      accept_r <= 1'b0;
      stuck_r  <= 1'b0;
    end else begin
      sync_r   <= {sync_r[SYNC_STAGES-2:0], raw};
      accept_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (s_s) begin
            state_r <= ARMING;
            cnt_r   <= CNT_ONE;
          end else begin
            cnt_r   <= CNT_ZERO;
          end
        end
        ARMING: begin
          if (!s_s) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
          end else if (cnt_r >= DEB_LAST) begin
            accept_r <= 1'b1;
            state_r  <= PRESSED;
            cnt_r    <= CNT_ZERO;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!s_s) begin
            state_r <= RELEASING;
            cnt_r   <= CNT_ONE;
          end else if (cnt_r >= STUCK_LAST) begin
            cnt_r   <= STUCK_MAX;
            stuck_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        RELEASING: begin
          if (s_s) begin
            state_r <= PRESSED;
            cnt_r   <= CNT_ZERO;
          end else if (cnt_r >= DEB_LAST) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

  assign accept = accept_r;
  assign active = (state_r != IDLE);
  assign stuck  = stuck_r;

endmodule

// File: rtl/coin_input_conditioner.sv
// Two debounced coin channels feeding a registered priority arbiter, so the
// accumulator sees at most one single-cycle coin pulse per clock.
module coin_input_conditioner
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic coin100_raw,
  input  logic coin500_raw,
  output logic moneda100,
  output logic moneda500,
  output logic busy,
  output logic stuck
);

  logic acc100_s, acc500_s, act100_s, act500_s, stk100_s, stk500_s;
  logic want100_s, want500_s;
  logic pend100_r, pend500_r, m100_r, m500_r, stuck_r;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_ch100 (
    .clk(clk), .rst(rst), .raw(coin100_raw),
    .accept(acc100_s), .active(act100_s), .stuck(stk100_s)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_ch500 (
    .clk(clk), .rst(rst), .raw(coin500_raw),
    .accept(acc500_s), .active(act500_s), .stuck(stk500_s)
  );

  // Effective request per channel: a held flag or a fresh accept
  always_comb begin
    want100_s = pend100_r | acc100_s;
    want500_s = pend500_r | acc500_s;
  end

  // Arbiter: 500 wins; a losing 100 request stays pending for the next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      pend100_r <= 1'b0;
      pend500_r <= 1'b0;
      m100_r    <= 1'b0;
      m500_r    <= 1'b0;
      stuck_r   <= 1'b0;
    end else begin
      m500_r    <= want500_s;
      m100_r    <= want100_s & ~want500_s;
      pend500_r <= 1'b0;
      pend100_r <= want100_s & want500_s;
      stuck_r   <= stuck_r | stk100_s | stk500_s;
    end
  end

  assign moneda100 = m100_r;
  assign moneda500 = m500_r;
  assign stuck     = stuck_r;
  assign busy      = act100_s | act500_s | pend100_r | pend500_r;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Self-checking bench: directed scenarios plus random bouncing inputs, compared
// against a run-length debounce model and a pending-coin arbiter model.
module tb_coin_input_conditioner;

  localparam int D     = 4;
  localparam int SYNC  = 2;
  localparam int LIMIT = 4 * D;

  logic clk = 1'b0;
  logic rst, coin100_raw, coin500_raw;
  logic moneda100, moneda500, busy, stuck;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // reference model state: index 0 = coin 100, index 1 = coin 500
  bit hist  [2][SYNC];
  bit lvl   [2];
  int run   [2];
  int held  [2];
  bit acc   [2];
  bit chstk [2];
  int npend [2];
  bit exp_m100, exp_m500, exp_stuck;

  always #5 clk = ~clk;

  coin_input_conditioner #(.DEBOUNCE_CYCLES(D), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst),
    .coin100_raw(coin100_raw), .coin500_raw(coin500_raw),
    .moneda100(moneda100), .moneda500(moneda500),
    .busy(busy), .stuck(stuck)
  );

  function automatic logic [3:0] exp_vec();
    logic b;
    b = lvl[0] || (run[0] != 0) || lvl[1] || (run[1] != 0) || (npend[0] > 0) || (npend[1] > 0);
    return {exp_m100, exp_m500, b, exp_stuck};
  endfunction

  // Advance the model by one clock edge with the raw levels present before it.
  task automatic model_edge(input bit r100, input bit r500);
    bit raw_v [2];
    bit s;
    raw_v[0] = r100;
    raw_v[1] = r500;
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        for (int k = 0; k < SYNC; k++) hist[c][k] = 1'b0;
        lvl[c] = 1'b0; run[c] = 0; held[c] = 0; acc[c] = 1'b0; chstk[c] = 1'b0; npend[c] = 0;
      end
      exp_m100 = 1'b0; exp_m500 = 1'b0; exp_stuck = 1'b0;
      return;
    end
    for (int c = 0; c < 2; c++) npend[c] += acc[c] ? 1 : 0;
    exp_m100 = 1'b0;
    exp_m500 = 1'b0;
    if (npend[1] > 0) begin
      exp_m500 = 1'b1; npend[1]--;
    end else if (npend[0] > 0) begin
      exp_m100 = 1'b1; npend[0]--;
    end
    exp_stuck = exp_stuck | chstk[0] | chstk[1];
    for (int c = 0; c < 2; c++) begin
      s = hist[c][SYNC-1];
      for (int k = SYNC - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
      hist[c][0] = raw_v[c];
      acc[c] = 1'b0;
      if (s != lvl[c]) begin
        run[c]++;
        held[c] = 0;
        if (run[c] == D) begin
          lvl[c] = s; run[c] = 0; acc[c] = s;
        end
      end else begin
        if (lvl[c] && run[c] == 0) begin
          if (held[c] < LIMIT) held[c]++;
          if (held[c] == LIMIT) chstk[c] = 1'b1;
        end else begin
          held[c] = 0;
        end
        run[c] = 0;
      end
    end
  endtask

  task automatic step(input logic a, input logic b);
    coin100_raw = a;
    coin500_raw = b;
    @(posedge clk);
    model_edge(a, b);
    #1;
    cyc++;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst = 1'b0;
    step(1'b0, 1'b0);
    cyc = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    checks++;
    if ({moneda100, moneda500, busy, stuck} !== 4'b0000) begin
      failures++; $display("FAIL reset_state got=%b exp=%b", {moneda100, moneda500, busy, stuck}, 4'b0000);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if ({moneda100, moneda500, busy, stuck} !== exp_vec()) begin
        failures++; $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, {moneda100, moneda500, busy, stuck}, exp_vec());
      end
    end
  endtask

  task automatic test_clean_press();
    int p100 = -1, c100 = 0, c500 = 0, idle_at = -1;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      step(i < 20, 1'b0);
      checks++;
      if ({moneda100, moneda500, busy, stuck} !== exp_vec()) begin
        failures++; $display("FAIL clean_press cyc=%0d got=%b exp=%b", cyc, {moneda100, moneda500, busy, stuck}, exp_vec());
      end
      if (moneda100) begin c100++; p100 = cyc; end
      if (moneda500) c500++;
      if (cyc >= 20 && !busy && idle_at < 0) idle_at = cyc;
    end
    checks++;
    if (c100 !== 1 || p100 !== 7) begin
      failures++; $display("FAIL clean_pulse count=%0d cycle=%0d exp count=1 cycle=7", c100, p100);
    end
    checks++;
    if (c500 !== 0) begin
      failures++; $display("FAIL clean_no500 count=%0d exp=0", c500);
    end
    checks++;
    if (idle_at !== 26) begin
      failures++; $display("FAIL clean_busy_drop cycle=%0d exp=26", idle_at);
    end
  endtask

  task automatic test_bounce();
    logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    int p500 = -1, c500 = 0, c100 = 0;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      step(1'b0, (i < 5) ? pat[i] : (i < 25));
      checks++;
      if ({moneda100, moneda500, busy, stuck} !== exp_vec()) begin
        failures++; $display("FAIL bounce cyc=%0d got=%b exp=%b", cyc, {moneda100, moneda500, busy, stuck}, exp_vec());
      end
      if (moneda500) begin c500++; p500 = cyc; end
      if (moneda100) c100++;
    end
    checks++;
    if (c500 !== 1 || p500 !== 12 || c100 !== 0) begin
      failures++; $display("FAIL bounce_pulse n500=%0d cycle=%0d n100=%0d exp 1/12/0", c500, p500, c100);
    end
  endtask

  task automatic test_simultaneous();
    int p100 = -1, p500 = -1, c100 = 0, c500 = 0, both = 0;
    apply_reset();
    for (int i = 0; i < 25; i++) begin
      step(i < 10, i < 10);
      checks++;
      if ({moneda100, moneda500, busy, stuck} !== exp_vec()) begin
        failures++; $display("FAIL simultaneous cyc=%0d got=%b exp=%b", cyc, {moneda100, moneda500, busy, stuck}, exp_vec());
      end
      if (moneda100) begin c100++; p100 = cyc; end
      if (moneda500) begin c500++; p500 = cyc; end
      if (moneda100 && moneda500) both++;
    end
    checks++;
    if (p500 !== 7 || p100 !== 8 || c100 !== 1 || c500 !== 1 || both !== 0) begin
      failures++; $display("FAIL simul_order m500@%0d m100@%0d n=%0d/%0d both=%0d exp 7/8 1/1 0", p500, p100, c500, c100, both);
    end
  endtask

  task automatic test_hold();
    int c100 = 0, stuck_at = -1;
    apply_reset();
    for (int i = 0; i < 110; i++) begin
      step(i < 100, 1'b0);
      checks++;
      if ({moneda100, moneda500, busy, stuck} !== exp_vec()) begin
        failures++; $display("FAIL hold cyc=%0d got=%b exp=%b", cyc, {moneda100, moneda500, busy, stuck}, exp_vec());
      end
      if (moneda100) c100++;
      if (stuck && stuck_at < 0) stuck_at = cyc;
    end
    checks++;
    if (c100 !== 1 || stuck_at !== 23 || stuck !== 1'b1) begin
      failures++; $display("FAIL hold_stuck pulses=%0d stuck_from=%0d stuck=%b exp 1/23/1", c100, stuck_at, stuck);
    end
    apply_reset();
    checks++;
    if (stuck !== 1'b0) begin
      failures++; $display("FAIL stuck_clear got=%b exp=0", stuck);
    end
  endtask

  task automatic test_reset_mid();
    int c100 = 0, p100 = -1;
    apply_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    rst = 1'b1;
    step(1'b1, 1'b0);
    checks++;
    if ({moneda100, moneda500, busy, stuck} !== 4'b0000) begin
      failures++; $display("FAIL reset_mid_outputs got=%b exp=%b", {moneda100, moneda500, busy, stuck}, 4'b0000);
    end
    step(1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0);
      if (moneda100 || moneda500) c100++;
    end
    checks++;
    if (c100 !== 0) begin
      failures++; $display("FAIL reset_mid_nopulse pulses=%0d exp=0", c100);
    end
    cyc = 0;
    for (int i = 0; i < 24; i++) begin
      step(i < 12, 1'b0);
      checks++;
      if ({moneda100, moneda500, busy, stuck} !== exp_vec()) begin
        failures++; $display("FAIL reset_mid_fresh cyc=%0d got=%b exp=%b", cyc, {moneda100, moneda500, busy, stuck}, exp_vec());
      end
      if (moneda100) p100 = cyc;
    end
    checks++;
    if (p100 !== 7) begin
      failures++; $display("FAIL fresh_latency cycle=%0d exp=7", p100);
    end
  endtask

  task automatic test_release_glitch();
    int c100 = 0, p_last = -1;
    logic a;
    apply_reset();
    for (int i = 0; i < 60; i++) begin
      a = (i < 12) || (i >= 13 && i < 20) || (i >= 32 && i < 44);
      step(a, 1'b0);
      checks++;
      if ({moneda100, moneda500, busy, stuck} !== exp_vec()) begin
        failures++; $display("FAIL release_glitch cyc=%0d got=%b exp=%b", cyc, {moneda100, moneda500, busy, stuck}, exp_vec());
      end
      if (moneda100) begin c100++; p_last = cyc; end
    end
    checks++;
    if (c100 !== 2 || p_last !== 39) begin
      failures++; $display("FAIL glitch_pulses count=%0d last=%0d exp 2/39", c100, p_last);
    end
  endtask

  task automatic test_random();
    int hold_left [2] = '{0, 0};
    logic lv [2] = '{1'b0, 1'b0};
    apply_reset();
    for (int i = 0; i < 2000; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (hold_left[c] == 0) begin
          lv[c] = 1'($urandom_range(0, 1));
          hold_left[c] = $urandom_range(1, 14);
        end
        hold_left[c]--;
      end
      rst = ($urandom_range(0, 399) == 0);
      step(lv[0], lv[1]);
      rst = 1'b0;
      checks++;
      if ({moneda100, moneda500, busy, stuck} !== exp_vec()) begin
        failures++; $display("FAIL random cyc=%0d got=%b exp=%b", cyc, {moneda100, moneda500, busy, stuck}, exp_vec());
      end
      checks++;
      if (moneda100 && moneda500) begin
        failures++; $display("FAIL random_exclusive cyc=%0d got=11 exp=not both", cyc);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    coin100_raw = 1'b0;
    coin500_raw = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_hold();
    test_reset_mid();
    test_release_glitch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
